// File: rtl/bcd_pkg.sv
// Shared types and constant helpers for the iterative binary-to-BCD converter.
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;

  typedef enum logic {
    IDLE,
    SHIFT
  } bcd_state_t;

  // 10^n as a 64-bit constant; valid for n <= 19.
  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  function automatic logic [127:0] max_bcd(input int unsigned digits);
    logic [127:0] r;
    r = '0;
    for (int unsigned i = 0; i < digits && i < 32; i++) r[i*4 +: 4] = 4'h9;
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adj
);

  always_comb begin
    adj = digit;
    if (digit >= 4'd5) adj = digit + 4'd3;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative shift-and-add-3 binary-to-packed-BCD converter with start/done handshake.
// Build option BCD_SATURATE_EN: on overflow, bcd reads as all nines.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [BIN_W-1:0]              bin,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                          overflow
);

  localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam logic [63:0] THRESH = pow10(DIGITS);
  // When 10^DIGITS already covers every BIN_W-bit value, overflow can never occur.
  localparam bit OVF_POSSIBLE = (BIN_W < 64) && (THRESH < (64'd1 << BIN_W));
`ifdef BCD_SATURATE_EN
  localparam logic [BCD_W-1:0] SAT_BCD = BCD_W'(max_bcd(DIGITS));
`endif

  bcd_state_t       state;
  logic [BIN_W-1:0] shreg;
  logic [BCD_W-1:0] work;
  logic [CNT_W-1:0] cnt;
  logic             ovf_pend;

  logic [BCD_W-1:0] adj_work;
  logic [BCD_W-1:0] next_work;
  logic [BIN_W-1:0] next_shreg;
  logic [63:0]      bin_ext;
  logic             ovf_in;
  logic             top_bit_unused;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit (work[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .adj   (adj_work[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  always_comb begin
    bin_ext    = 64'(bin);
    ovf_in     = OVF_POSSIBLE && (bin_ext >= THRESH);
    next_shreg = shreg << 1;
    // Bit leaving the top digit is dropped, leaving bin mod 10^DIGITS in the lower digits.
    {top_bit_unused, next_work} = {adj_work, shreg[BIN_W-1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
      shreg    <= '0;
      work     <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            shreg    <= bin;
            work     <= '0;
            cnt      <= '0;
            ovf_pend <= ovf_in;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          shreg <= next_shreg;
          work  <= next_work;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_W'(BIN_W - 1)) begin
`ifdef BCD_SATURATE_EN
            bcd <= ovf_pend ? SAT_BCD : next_work;
`else
            bcd <= next_work;
`endif
            overflow <= ovf_pend;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq (16/5 and 16/2 configurations).
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic [15:0] bin = '0;

  logic        busy_a, done_a, ovf_a;
  logic [19:0] bcd_a;
  logic        busy_b, done_b, ovf_b;
  logic [7:0]  bcd_b;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .bin(bin),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .overflow(ovf_a)
  );

  bin_to_bcd_seq #(.BIN_W(16), .DIGITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .bin(bin),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .overflow(ovf_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] ref_bcd(input int unsigned v);
    logic [19:0] r;
    r = '0;
    for (int d = 0; d < 5; d++) begin
      r[d*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic wait_done(input bit sel, output int n);
    n = 0;
    while (!(sel ? done_b : done_a) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic convert(input bit sel, input logic [15:0] v, output logic [19:0] res,
                         output logic ov, output int lat, output int bcnt);
    bin = v;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    lat  = 0;
    bcnt = int'(sel ? busy_b : busy_a);
    while (!(sel ? done_b : done_a) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      bcnt += int'(sel ? busy_b : busy_a);
    end
    res = sel ? {12'h000, bcd_b} : bcd_a;
    ov  = sel ? ovf_b : ovf_a;
  endtask

  logic [15:0] va [5] = '{16'd0, 16'd65535, 16'd1234, 16'd40960, 16'd10};
  logic [19:0] ea [5] = '{20'h00000, 20'h65535, 20'h01234, 20'h40960, 20'h00010};

  logic [15:0] vb [5] = '{16'd99, 16'd100, 16'd1234, 16'd65535, 16'd7};
  logic        ob [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
`ifdef BCD_SATURATE_EN
  logic [7:0]  eb [5] = '{8'h99, 8'h99, 8'h99, 8'h99, 8'h07};
`else
  logic [7:0]  eb [5] = '{8'h99, 8'h00, 8'h34, 8'h35, 8'h07};
`endif

  initial begin
    logic [19:0] res;
    logic        ov;
    int          lat, bcnt, n, t1, t2, pulses;
    logic [15:0] rv;

    @(posedge clk); #1;
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_done_a", 32'(done_a), 32'd0);
    check("rst_bcd_a",  32'(bcd_a),  32'd0);
    check("rst_ovf_a",  32'(ovf_a),  32'd0);
    check("rst_bcd_b",  32'(bcd_b),  32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      convert(1'b0, va[i], res, ov, lat, bcnt);
      check($sformatf("a_bcd_%0d", va[i]), 32'(res), 32'(ea[i]));
      check($sformatf("a_ovf_%0d", va[i]), 32'(ov), 32'd0);
      check($sformatf("a_lat_%0d", va[i]), 32'(lat), 32'd16);
      check($sformatf("a_busy_%0d", va[i]), 32'(bcnt), 32'd16);
      @(posedge clk); #1;
      check($sformatf("a_done_pulse_%0d", va[i]), 32'(done_a), 32'd0);
      check($sformatf("a_bcd_held_%0d", va[i]), 32'(bcd_a), 32'(ea[i]));
    end

    for (int i = 0; i < 5; i++) begin
      convert(1'b1, vb[i], res, ov, lat, bcnt);
      check($sformatf("b_bcd_%0d", vb[i]), 32'(res), 32'(eb[i]));
      check($sformatf("b_ovf_%0d", vb[i]), 32'(ov), 32'(ob[i]));
      check($sformatf("b_lat_%0d", vb[i]), 32'(lat), 32'd16);
    end

    for (int i = 0; i < 20; i++) begin
      rv = 16'($urandom_range(0, 65535));
      convert(1'b0, rv, res, ov, lat, bcnt);
      check($sformatf("sweep_%0d", rv), 32'(res), 32'(ref_bcd(int'(rv))));
    end

    // back-to-back with start held high
    bin = 16'd42;
    start_a = 1'b1;
    @(posedge clk); #1;
    bin = 16'd7;
    wait_done(1'b0, n);
    t1 = cyc;
    check("b2b_first_seen", 32'(n < 40), 32'd1);
    check("b2b_first_bcd", 32'(bcd_a), 32'h00042);
    @(posedge clk); #1;
    start_a = 1'b0;
    check("b2b_second_accept", 32'(busy_a), 32'd1);
    wait_done(1'b0, n);
    t2 = cyc;
    check("b2b_spacing", 32'(t2 - t1), 32'd17);
    check("b2b_second_bcd", 32'(bcd_a), 32'h00007);
    @(posedge clk); #1;

    // start re-pulsed mid-conversion is ignored
    bin = 16'd300;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("mid_bcd_hold", 32'(bcd_a), 32'h00007);
    bin = 16'd9;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    wait_done(1'b0, n);
    check("ignore_bcd", 32'(bcd_a), 32'h00300);
    pulses = 0;
    repeat (20) begin @(posedge clk); #1; pulses += int'(done_a); end
    check("ignore_no_extra_done", 32'(pulses), 32'd0);

    // leave dut_b with a nonzero result and overflow flagged
    convert(1'b1, 16'd100, res, ov, lat, bcnt);
    check("pre_rst_ovf_b", 32'(ovf_b), 32'd1);

    // reset mid-conversion
    bin = 16'd500;
    start_a = 1'b1;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("mrst_busy_a", 32'(busy_a), 32'd0);
    check("mrst_done_a", 32'(done_a), 32'd0);
    check("mrst_bcd_a",  32'(bcd_a),  32'd0);
    check("mrst_busy_b", 32'(busy_b), 32'd0);
    check("mrst_ovf_b",  32'(ovf_b),  32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pulses = 0;
    repeat (25) begin @(posedge clk); #1; pulses += int'(done_a) + int'(done_b); end
    check("mrst_no_done", 32'(pulses), 32'd0);
    check("mrst_bcd_a_stays", 32'(bcd_a), 32'd0);
    convert(1'b0, 16'd500, res, ov, lat, bcnt);
    check("post_rst_bcd", 32'(res), 32'h00500);
    check("post_rst_lat", 32'(lat), 32'd16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Parametrised, iterative binary-to-packed-BCD converter using the shift-and-add-3 (double dabble) method. It replaces fixed lookup-table conversion for display paths such as seven-segment drivers and counters. It accepts any BIN_W-bit value and produces DIGITS BCD digits through a start/done handshake. Overflow is detected and flagged; saturation is selectable at build time.

Parameters:
BIN_W, 16, binary input width in bits (>=1)
DIGITS, 5, number of BCD output digits (>=1); output width is 4*DIGITS

Ports:
clk  in  1  system clock, rising-edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request a conversion; sampled only in IDLE
bin  in  BIN_W  binary value; captured on the accepting edge only
busy  out  1  high while a conversion is in progress
done  out  1  one-cycle pulse: bcd and overflow are valid and updated
bcd  out  4*DIGITS  packed BCD result; digit 0 in [3:0]; held between done pulses
overflow  out  1  bin >= 10^DIGITS for the last completed conversion; held with bcd

Behaviour:
- Reset (async assert, sync release): state=IDLE, busy=0, done=0, bcd=0, overflow=0, internal shift/count registers cleared. Reset mid-conversion aborts the conversion with no done pulse.
- FSM states: IDLE, SHIFT.
- IDLE: if start=1 at edge k, the block loads bin into the shift register, clears the BCD working register and count, computes ovf_pend = (bin >= 10^DIGITS), and moves to SHIFT. When 10^DIGITS >= 2^BIN_W, ovf_pend is constant 0.
- SHIFT: on each edge, every working digit >= 5 gets +3, then {work, shreg} shifts left by 1 and count increments. The working register is 4*DIGITS bits; bits shifted out of the top digit are discarded.
- On the BIN_W-th SHIFT edge (edge k+BIN_W), the block loads bcd from the final working value, loads overflow from ovf_pend, drives done=1 for that one cycle, and returns to IDLE.
- busy=1 for cycles after edges k..k+BIN_W-1. It falls on the same edge that raises done.
- Latency: done is seen BIN_W edges after the accepting edge. Throughput is one conversion per BIN_W+1 cycles, because start asserted during the done cycle is accepted.
- start while busy=1 is ignored: no queueing and no error. bin changes during SHIFT have no effect.
- Outputs change only on the done edge or on reset.

Optional Feature:
BCD_SATURATE_EN
- Defined: when overflow is set, bcd is forced to all digits 9 (e.g. 16'h0099 for DIGITS=2). Otherwise bcd is the true result.
- Undefined: bcd is bin mod 10^DIGITS, i.e. the low DIGITS decimal digits. overflow is still reported.
- Ports, latency and handshake are identical in both builds.

Decomposition:
- Package bcd_pkg holds:
  - typedef enum for the FSM states;
  - localparam BCD_DIGIT_W = 4;
  - constant function pow10(n) returning 10^n, used for the overflow threshold;
  - function max_bcd(digits) returning all-9s packed BCD.
- Sub-module bcd_digit_adj: combinational 4-bit "if >=5 add 3", instantiated DIGITS times via generate inside the SHIFT datapath.
- Counter width is $clog2(BIN_W+1).

Test Plan:
- BIN_W=16, DIGITS=5, bin=0, start pulse -> done 16 edges later, bcd=20'h00000, overflow=0, busy high exactly 16 cycles.
- BIN_W=16, DIGITS=5, bin=65535 -> bcd=20'h65535, overflow=0; bin=1234 -> bcd=20'h01234.
- BIN_W=16, DIGITS=2, bin=99 -> bcd=8'h99, overflow=0; bin=100 -> overflow=1, bcd=8'h99 with BCD_SATURATE_EN, 8'h00 without; bin=1234 without the macro -> bcd=8'h34.
- Throughput and handshake:
  - back-to-back: start held high with bin=42 then 7 -> done pulses 17 cycles apart, bcd 0x00042 then 0x00007;
  - start re-pulsed with bin=9 mid-conversion -> ignored, first result unchanged.
- Reset robustness: rst_n low at cycle 5 of a conversion of 500 -> busy, done, bcd and overflow immediately 0 and no done pulse; a new conversion of 500 after release -> bcd=20'h00500.
- Random sweep, 10k values per configuration (BIN_W=8/DIGITS=3, BIN_W=20/DIGITS=4), scoreboarded against a reference divide-by-10 model, both macro settings.
